// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, write-port roles and architectural register numbers
package reg_file_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 4;
   localparam int WP_ALU = 0;
   localparam int WP_LOAD = 1;
   localparam int REG_PC = 15;
   localparam int REG_LR = 14;
   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register pending-load bits feeding load-use stall detection
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NR = 3,
   parameter int NW = 2,
   parameter int PC_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NW-1:0]     wr_en,
   input  logic [NW*ADDR_W-1:0] wr_addr,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr,
   input  logic [NR*ADDR_W-1:0] rd_addr,
   input  logic [NR-1:0]     rd_hit,
   output logic [NR-1:0]     rd_pend,
   output logic              any_pend
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A = '1;
   logic [DEPTH-1:0] pend, pend_nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) pend <= '0;
      else pend <= pend_nxt;
   // clears first so a new load to the same register supersedes its writeback
   always_comb begin
      pend_nxt = pend;
      for (int k = 0; k < NW; k++)
         if (wr_en[k]) pend_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      if (pend_set && !(PC_REG != 0 && pend_addr == PC_A)) pend_nxt[pend_addr] = 1'b1;
   end
   for (genvar r = 0; r < NR; r++) begin : g_rp
      logic [ADDR_W-1:0] ra;
      assign ra = rd_addr[r*ADDR_W +: ADDR_W];
      assign rd_pend[r] = pend[ra] & ~rd_hit[r] & ~(PC_REG != 0 && ra == PC_A);
   end
   assign any_pend = |pend;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write bypass, PC read override and load scoreboard
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NR = 3,
   parameter int NW = 2,
   parameter int PC_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NW-1:0]        wr_en,
   input  logic [NW*ADDR_W-1:0] wr_addr,
   input  logic [NW*DATA_W-1:0] wr_data,
   input  logic [NR*ADDR_W-1:0] rd_addr,
   output logic [NR*DATA_W-1:0] rd_data,
   output logic [NR-1:0]        rd_pend,
   input  logic [DATA_W-1:0]    pc_plus8,
   input  logic                 pend_set,
   input  logic [ADDR_W-1:0]    pend_addr,
   output logic                 any_pend
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A = '1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [NR-1:0] rd_hit;
   // later ports overwrite earlier ones, so the highest index wins a collision
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      end else begin
         for (int k = 0; k < NW; k++)
            if (wr_en[k] && !(PC_REG != 0 && wr_addr[k*ADDR_W +: ADDR_W] == PC_A))
               mem[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
      end
   for (genvar r = 0; r < NR; r++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] byp;
      logic hit;
      assign ra = rd_addr[r*ADDR_W +: ADDR_W];
      always_comb begin
         hit = 1'b0;
         byp = mem[ra];
         for (int k = 0; k < NW; k++)
            if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == ra) begin
               hit = 1'b1;
               byp = wr_data[k*DATA_W +: DATA_W];
            end
      end
      assign rd_hit[r] = hit & ~rst;
      assign rd_data[r*DATA_W +: DATA_W] = (PC_REG != 0 && ra == PC_A) ? pc_plus8 : rst ? '0 : byp;
   end
   reg_file_scoreboard #(.ADDR_W(ADDR_W), .NR(NR), .NW(NW), .PC_REG(PC_REG)) u_sb (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .pend_set(pend_set),
      .pend_addr(pend_addr), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_pend(rd_pend),
      .any_pend(any_pend)
   );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed steps with an expectation queue checked after each drive
module tb_reg_file_mp;
   import reg_file_pkg::*;
   localparam int NR = 3;
   localparam int NW = 2;
   localparam int AW = DEF_ADDR_W;
   localparam int DW = DEF_DATA_W;
   typedef struct {
      string tag;
      int sel;
      logic [31:0] val;
   } exp_t;
   logic clk = 1'b0;
   logic rst;
   logic [NW-1:0] wr_en;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0] rd_pend;
   reg_data_t pc_plus8;
   logic pend_set;
   reg_addr_t pend_addr;
   logic any_pend;
   exp_t q[$];
   int compared = 0;
   int mismatched = 0;
   always #5 clk = ~clk;
   reg_file_mp dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend), .pc_plus8(pc_plus8),
      .pend_set(pend_set), .pend_addr(pend_addr), .any_pend(any_pend)
   );
   // sel: 0..2 rd_data port, 10..12 rd_pend port, 20 any_pend
   function automatic logic [31:0] observe(int sel);
      if (sel < 10) return rd_data[sel*DW +: DW];
      if (sel < 20) return {31'b0, rd_pend[sel-10]};
      return {31'b0, any_pend};
   endfunction
   task automatic push(string tag, int sel, logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      q.push_back(e);
   endtask
   task automatic check_all();
      exp_t e;
      logic [31:0] o;
      while (q.size() > 0) begin
         e = q.pop_front();
         o = observe(e.sel);
         compared++;
         assert (o === e.val) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
         end
      end
   endtask
   task automatic step();
      @(negedge clk);
      wr_en = '0;
      pend_set = 1'b0;
   endtask
   task automatic wr(int k, int a, logic [31:0] d);
      wr_en[k] = 1'b1;
      wr_addr[k*AW +: AW] = AW'(a);
      wr_data[k*DW +: DW] = d;
   endtask
   task automatic rd(int i, int a);
      rd_addr[i*AW +: AW] = AW'(a);
   endtask
   task automatic settle();
      #1 check_all();
   endtask
   initial begin
      rst = 1'b1;
      wr_en = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      pc_plus8 = 32'h0000_0108;
      pend_set = 1'b0;
      pend_addr = '0;
      rd(2, REG_PC);
      step();
      step();
      push("reset_rd0", 0, 32'h0);
      push("reset_pc", 2, 32'h108);
      push("reset_pend_pc", 12, 32'h0);
      push("reset_any", 20, 32'h0);
      settle();
      step();
      rst = 1'b0;
      // bypass then array read of R5
      step();
      wr(WP_ALU, 5, 32'h1234_5678);
      rd(0, 5);
      push("byp_r5", 0, 32'h1234_5678);
      settle();
      step();
      push("mem_r5", 0, 32'h1234_5678);
      settle();
      // distinct addresses on both ports
      step();
      wr(WP_ALU, 8, 32'h0000_0011);
      wr(WP_LOAD, 9, 32'h0000_0022);
      step();
      rd(0, 8);
      rd(1, 9);
      push("mem_r8", 0, 32'h11);
      push("mem_r9", 1, 32'h22);
      settle();
      // same-address collision: port 1 wins
      step();
      wr(WP_ALU, 7, 32'hAAAA_0000);
      wr(WP_LOAD, 7, 32'h5555_0000);
      rd(0, 7);
      push("coll_byp", 0, 32'h5555_0000);
      settle();
      step();
      push("coll_mem", 0, 32'h5555_0000);
      settle();
      // PC override and discarded PC writes
      step();
      wr(WP_ALU, REG_PC, 32'hFFFF_FFFF);
      pend_set = 1'b1;
      pend_addr = reg_addr_t'(REG_PC);
      push("pc_wr_byp", 2, 32'h108);
      settle();
      step();
      push("pc_after_wr", 2, 32'h108);
      push("pc_no_pend", 20, 32'h0);
      push("pc_rdpend", 12, 32'h0);
      settle();
      step();
      pc_plus8 = 32'h0000_010C;
      push("pc_track", 2, 32'h10C);
      settle();
      // pending load to R2, then writeback on load port
      step();
      pend_set = 1'b1;
      pend_addr = 4'd2;
      rd(0, 2);
      push("pend_same_cyc", 10, 32'h0);
      push("any_same_cyc", 20, 32'h0);
      settle();
      step();
      push("pend_r2", 10, 32'h1);
      push("any_r2", 20, 32'h1);
      settle();
      step();
      wr(WP_LOAD, 2, 32'h0000_0042);
      push("ld_clear_pend", 10, 32'h0);
      push("ld_byp", 0, 32'h42);
      push("ld_any_held", 20, 32'h1);
      settle();
      step();
      push("ld_any_drop", 20, 32'h0);
      push("ld_mem", 0, 32'h42);
      settle();
      // set and clear on R4 in one cycle: set wins
      step();
      pend_set = 1'b1;
      pend_addr = 4'd4;
      wr(WP_LOAD, 4, 32'h0000_0099);
      rd(1, 4);
      push("sc_byp", 1, 32'h99);
      push("sc_pend_now", 11, 32'h0);
      settle();
      step();
      push("sc_pend", 11, 32'h1);
      push("sc_mem", 1, 32'h99);
      push("sc_any", 20, 32'h1);
      settle();
      step();
      wr(WP_LOAD, 4, 32'h0000_0077);
      // mid-run reset after R3 write with a load outstanding
      step();
      wr(WP_ALU, 3, 32'hDEAD_BEEF);
      pend_set = 1'b1;
      pend_addr = 4'd6;
      step();
      rd(0, 5);
      rd(1, 3);
      push("pre_rst_r3", 1, 32'hDEAD_BEEF);
      push("pre_rst_any", 20, 32'h1);
      settle();
      rst = 1'b1;
      push("rst_r3", 1, 32'h0);
      push("rst_r5", 0, 32'h0);
      push("rst_any", 20, 32'h0);
      push("rst_pc", 2, 32'h10C);
      settle();
      step();
      rst = 1'b0;
      // late load writeback after reset
      step();
      wr(WP_LOAD, 6, 32'h0000_0066);
      rd(0, 6);
      push("late_pend", 10, 32'h0);
      settle();
      step();
      push("late_mem", 0, 32'h66);
      push("late_any", 20, 32'h0);
      settle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
